// File: rtl/bht_scheduler.sv
// bht_scheduler
//   Branch history table of 2^IDX_W two-bit saturating counters. The table has
//   one access slot per cycle. That slot is shared between fetch-side
//   prediction lookups and execute-side resolution updates. Updates are
//   buffered in a small in-order queue, so execute never waits on fetch.
//
// Ports
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   req_valid     fetch requests a prediction for req_idx
//   req_ready     lookup granted this cycle (combinational)
//   pred_valid    pred_taken is valid, one cycle after the grant (registered)
//   pred_taken    predicted direction, 1 = taken (holds while pred_valid=0)
//   upd_valid     resolved branch (upd_idx, upd_taken) presented by execute
//   upd_ready     update queue has room at the start of this cycle
//   q_count       current update queue occupancy
module bht_scheduler #(
  parameter int          IDX_W      = 4,
  parameter int          QDEPTH     = 4,
  parameter int          STARVE_LIM = 3,
  parameter logic [1:0]  INIT       = 2'b11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [IDX_W-1:0]          req_idx,
  output logic                      req_ready,
  output logic                      pred_valid,
  output logic                      pred_taken,
  input  logic                      upd_valid,
  input  logic [IDX_W-1:0]          upd_idx,
  input  logic                      upd_taken,
  output logic                      upd_ready,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int NENT  = 2 ** IDX_W;
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_LOOKUP,
    SLOT_DRAIN
  } slot_e;

  logic [1:0]       r_table [NENT];
  logic [IDX_W-1:0] r_qIdx  [QDEPTH];
  logic             r_qTaken[QDEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic [SW-1:0]    r_starve;
  logic             r_predValid;
  logic             r_predTaken;

  slot_e            w_slot;
  logic             w_qEmpty;
  logic             w_qFull;
  logic             w_enq;
  logic             w_pop;
  logic [IDX_W-1:0] w_headIdx;
  logic             w_headTaken;
  logic [1:0]       w_headVal;
  logic [1:0]       w_newVal;

  assign w_qEmpty    = (r_count == '0);
  assign w_qFull     = (r_count == CNT_W'(QDEPTH));
  assign w_headIdx   = r_qIdx[r_rdPtr];
  assign w_headTaken = r_qTaken[r_rdPtr];
  assign w_headVal   = r_table[w_headIdx];

  // Slot arbitration. A full queue always wins so execute keeps flowing; a
  // starved queue wins once fetch has had STARVE_LIM grants in a row;
  // otherwise fetch has priority and the queue soaks up otherwise idle slots.
  always_comb begin
    w_slot = SLOT_IDLE;
    if (w_qFull) begin
      w_slot = SLOT_DRAIN;
    end else if (!w_qEmpty && (r_starve == SW'(STARVE_LIM))) begin
      w_slot = SLOT_DRAIN;
    end else if (req_valid) begin
      w_slot = SLOT_LOOKUP;
    end else if (!w_qEmpty) begin
      w_slot = SLOT_DRAIN;
    end
  end

  assign req_ready  = (w_slot == SLOT_LOOKUP);
  assign upd_ready  = !w_qFull;
  assign w_enq      = upd_valid && upd_ready;
  assign w_pop      = (w_slot == SLOT_DRAIN);
  assign pred_valid = r_predValid;
  assign pred_taken = r_predTaken;
  assign q_count    = r_count;

  // Saturating step of the counter at the queue head; it pins at 0 and 3.
  always_comb begin
    w_newVal = w_headVal;
    if (w_headTaken && (w_headVal != 2'd3)) begin
      w_newVal = w_headVal + 2'd1;
    end else if (!w_headTaken && (w_headVal != 2'd0)) begin
      w_newVal = w_headVal - 2'd1;
    end
  end

  // Queue payload storage. It needs no reset because the pointers and the
  // count decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_qIdx[r_wrPtr]   <= upd_idx;
      r_qTaken[r_wrPtr] <= upd_taken;
    end
  end

  // Table, queue control, starvation tracking and the prediction register.
  // Reset discards any queued updates and restores every counter to INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) begin
        r_table[i] <= INIT;
      end
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_predValid <= 1'b0;
      r_predTaken <= 1'b0;
    end else begin
      r_predValid <= (w_slot == SLOT_LOOKUP);
      if (w_slot == SLOT_LOOKUP) begin
        r_predTaken <= r_table[req_idx][1];
      end

      if (w_pop) begin
        r_table[w_headIdx] <= w_newVal;
        r_rdPtr            <= r_rdPtr + 1'b1;
      end

      if (w_enq) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end

      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Only lookups that bypass waiting updates count toward starvation.
      if ((w_slot == SLOT_LOOKUP) && !w_qEmpty) begin
        if (r_starve != SW'(STARVE_LIM)) begin
          r_starve <= r_starve + 1'b1;
        end
      end else begin
        r_starve <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bht_scheduler.sv
// tb_bht_scheduler
//   Randomised and directed stimulus for bht_scheduler. A behavioural model
//   (an integer array for the table and a queue of pending updates) predicts
//   the grant decisions and the prediction values. The driver checks the
//   combinational handshakes and pushes expected predictions into a
//   scoreboard. A monitor pops the scoreboard whenever the DUT shows a
//   prediction.
module tb_bht_scheduler;

  localparam int IDX_W      = 4;
  localparam int QDEPTH     = 4;
  localparam int STARVE_LIM = 3;
  localparam int NENT       = 2 ** IDX_W;
  localparam int CW         = $clog2(QDEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             req_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic [CW-1:0]    q_count;

  bht_scheduler #(
    .IDX_W(IDX_W), .QDEPTH(QDEPTH), .STARVE_LIM(STARVE_LIM), .INIT(2'b11)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .q_count(q_count)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int mTab[NENT];
  int mQIdx[$];
  int mQTaken[$];
  int mStarve;
  int expQ[$];

  // Pending transactions that fetch and execute hold until they are accepted.
  bit pendReq;
  int pendReqIdx;
  bit pendUpd;
  int pendUpdIdx;
  int pendUpdTaken;
  int reqPct;
  int updPct;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NENT; i++) mTab[i] = 3;
    mQIdx.delete();
    mQTaken.delete();
    mStarve = 0;
    expQ.delete();
  endtask

  // Assert reset a little after a rising edge so that the effect is clearly
  // asynchronous. Then check the outputs before the next edge arrives.
  task automatic resetDut();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    req_valid = 1'b0;
    upd_valid = 1'b0;
    pendReq   = 1'b0;
    pendUpd   = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_q_count", int'(q_count), 0);
    checkOutput("rst_pred_valid", int'(pred_valid), 0);
    checkOutput("rst_pred_taken", int'(pred_taken), 0);
    checkOutput("rst_upd_ready", int'(upd_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle. Drive the pending traffic at the falling edge. Then let
  // the model decide the slot from occupancy, starvation and request, compare
  // the handshakes, and advance the model.
  task automatic applyStimulus();
    int qs;
    int slot;
    @(negedge clk);
    if (!pendReq && ($urandom_range(99) < reqPct)) begin
      pendReq    = 1'b1;
      pendReqIdx = $urandom_range(NENT - 1);
    end
    if (!pendUpd && ($urandom_range(99) < updPct)) begin
      pendUpd      = 1'b1;
      pendUpdIdx   = $urandom_range(NENT - 1);
      pendUpdTaken = $urandom_range(1);
    end
    req_valid = pendReq;
    req_idx   = IDX_W'(pendReqIdx);
    upd_valid = pendUpd;
    upd_idx   = IDX_W'(pendUpdIdx);
    upd_taken = pendUpdTaken[0];
    #1;

    qs = mQIdx.size();
    if (qs == QDEPTH)                         slot = 2;
    else if (qs > 0 && mStarve == STARVE_LIM) slot = 2;
    else if (pendReq)                         slot = 1;
    else if (qs > 0)                          slot = 2;
    else                                      slot = 0;

    checkOutput("req_ready", int'(req_ready), (slot == 1) ? 1 : 0);
    checkOutput("upd_ready", int'(upd_ready), (qs < QDEPTH) ? 1 : 0);
    checkOutput("q_count", int'(q_count), qs);

    if (slot == 1) begin
      expQ.push_back((mTab[pendReqIdx] >= 2) ? 1 : 0);
      pendReq = 1'b0;
      mStarve = (qs > 0) ? ((mStarve < STARVE_LIM) ? mStarve + 1 : STARVE_LIM) : 0;
    end else begin
      mStarve = 0;
    end

    if (slot == 2) begin
      int hi;
      int ht;
      hi = mQIdx.pop_front();
      ht = mQTaken.pop_front();
      if (ht == 1) mTab[hi] = (mTab[hi] < 3) ? mTab[hi] + 1 : 3;
      else         mTab[hi] = (mTab[hi] > 0) ? mTab[hi] - 1 : 0;
    end

    if (pendUpd && qs < QDEPTH) begin
      mQIdx.push_back(pendUpdIdx);
      mQTaken.push_back(pendUpdTaken);
      pendUpd = 1'b0;
    end
  endtask

  task automatic issueReq(input int idx);
    pendReq    = 1'b1;
    pendReqIdx = idx;
    for (int k = 0; k < 16 && pendReq; k++) applyStimulus();
  endtask

  task automatic issueUpd(input int idx, input int taken);
    pendUpd      = 1'b1;
    pendUpdIdx   = idx;
    pendUpdTaken = taken;
    for (int k = 0; k < 16 && pendUpd; k++) applyStimulus();
  endtask

  // Scoreboard monitor. Every grant must produce exactly one prediction on
  // the following cycle, and no prediction may appear without a grant.
  always @(negedge clk) begin
    if (!rst) begin
      if (pred_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("pred_spurious", 1, 0);
        end else begin
          checkOutput("pred_taken", int'(pred_taken), expQ.pop_front());
        end
      end else if (expQ.size() != 0) begin
        checkOutput("pred_missing", 0, 1);
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_idx   = '0;
    upd_valid = 1'b0;
    upd_idx   = '0;
    upd_taken = 1'b0;
    pendReq   = 1'b0;
    pendUpd   = 1'b0;
    reqPct    = 0;
    updPct    = 0;
    modelReset();
    resetDut();

    // First lookup after reset, then a counter walked down and then held at 0.
    issueReq(5);
    applyStimulus();
    for (int n = 0; n < 3; n++) issueUpd(2, 0);
    repeat (4) applyStimulus();
    issueReq(2);
    issueUpd(2, 0);
    repeat (3) applyStimulus();
    issueReq(2);
    applyStimulus();

    // Continuous fetch with a single update waiting: a forced drain is expected.
    reqPct = 100;
    issueUpd(4, 0);
    repeat (8) applyStimulus();

    // Back-to-back updates against continuous fetch fill the queue.
    updPct = 100;
    repeat (6) applyStimulus();
    updPct = 0;
    repeat (8) applyStimulus();

    // Saturation upward from 0, with a lookup after each step.
    reqPct = 0;
    for (int n = 0; n < 3; n++) issueUpd(7, 0);
    repeat (4) applyStimulus();
    for (int n = 0; n < 5; n++) begin
      issueUpd(7, 1);
      repeat (2) applyStimulus();
      issueReq(7);
    end
    applyStimulus();

    // Reset with three updates still queued; afterwards every entry is INIT.
    reqPct = 100;
    for (int n = 0; n < 3; n++) issueUpd(9, 0);
    reqPct = 0;
    resetDut();
    for (int i = 0; i < NENT; i++) issueReq(i);
    applyStimulus();

    // Random traffic with a reset in the middle.
    reqPct = 60;
    updPct = 50;
    repeat (1500) applyStimulus();
    resetDut();
    reqPct = 80;
    updPct = 40;
    repeat (1500) applyStimulus();

    reqPct  = 0;
    updPct  = 0;
    pendReq = 1'b0;
    pendUpd = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bht_scheduler.md
Name: bht_scheduler

Overview:
- Table of 2^IDX_W two-bit saturating branch counters, shared between the fetch-side prediction lookup port and the execute-side branch-resolution update port.
- The table storage has one access slot per cycle; this block arbitrates that slot.
- Resolution updates are buffered in a small in-order queue so execute never stalls on a lookup.
- Sits between fetch (req/pred) and execute (upd) in the pipeline front end.

Parameters:
- IDX_W, 4: table index width; table holds 2^IDX_W entries.
- QDEPTH, 4: update queue depth, power of 2, at least 2.
- STARVE_LIM, 3: consecutive lookup grants allowed while the queue is non-empty before one drain cycle is forced.
- INIT, 2'b11: reset value of every counter (strongly taken).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch requests a prediction.
- req_idx  in  IDX_W  table index for the lookup.
- req_ready  out  1  lookup granted this cycle (combinational).
- pred_valid  out  1  pred_taken is valid (registered).
- pred_taken  out  1  predicted direction; 1 = taken.
- upd_valid  in  1  resolved branch presented.
- upd_idx  in  IDX_W  table index of the resolved branch.
- upd_taken  in  1  actual outcome; 1 = taken.
- upd_ready  out  1  queue accepts the update this cycle.
- q_count  out  $clog2(QDEPTH)+1  current queue occupancy.

Behaviour:
- Reset (asynchronous, may assert at any time, including mid-drain):
  - All counters return to INIT.
  - Queue is emptied; queued updates are discarded.
  - pred_valid=0, pred_taken=0, q_count=0, starve counter=0.
  - Outputs take these values immediately on rst assertion.
- Slot arbitration, evaluated each cycle; exactly one of LOOKUP, DRAIN or IDLE:
  - DRAIN if the queue is full.
  - DRAIN if the queue is non-empty and starve==STARVE_LIM.
  - Otherwise LOOKUP if req_valid=1.
  - Otherwise DRAIN if the queue is non-empty.
  - Otherwise IDLE.
- req_ready=1 exactly in LOOKUP cycles. Fetch holds req_valid/req_idx until accepted.
- LOOKUP: pred_taken <= table[req_idx][1]; pred_valid <= 1 on the next edge. Latency is 1 cycle.
  - If req_ready=0, pred_valid is 0 in the following cycle.
  - pred_taken holds its last value while pred_valid=0.
- DRAIN: pop the queue head (idx, taken) and read-modify-write that entry in the same cycle:
  - taken=1 and entry!=3: entry+1.
  - taken=0 and entry!=0: entry-1.
  - Otherwise the entry is unchanged (saturated).
  - Arithmetic is 2-bit and never wraps.
- Starve counter:
  - LOOKUP with a non-empty queue: starve+1, saturating at STARVE_LIM.
  - Any DRAIN, or an empty queue: starve=0.
- No forwarding: a lookup sees table contents as of its grant cycle. Queued, undrained updates are not visible.
- A DRAIN write and a LOOKUP never occur in the same cycle.
- Queue behaviour:
  - upd_ready = (q_count < QDEPTH), combinational, based on start-of-cycle occupancy. A drain in the same cycle does not raise upd_ready.
  - Enqueue on upd_valid & upd_ready. Pops are strictly FIFO.
  - Simultaneous enqueue and pop is allowed; q_count is unchanged.
  - Read and write pointers are IDX-independent and wrap modulo QDEPTH.
  - upd_valid while full: the update is not accepted; the source must hold it.
- Repeated updates to the same index apply in arrival order, one per DRAIN cycle.

Test Plan:
- Reset, then request idx 5 -> req_ready=1; next cycle pred_valid=1, pred_taken=1 (INIT=3); q_count=0.
- Enqueue 3 not-taken updates to idx 2 with req_valid=0 -> drains over 3 cycles; entry 2 goes 3->2->1->0; then lookup idx 2 gives pred_taken=0. A 4th not-taken update leaves the entry at 0.
- Hold req_valid=1 continuously and enqueue 1 update -> lookups granted for 3 cycles, 4th cycle forced DRAIN (req_ready=0), then lookups resume; starve resets to 0.
- Enqueue 4 updates back-to-back with req_valid=1 -> q_count reaches 4, upd_ready=0, next cycle DRAIN, req_ready=0. Enqueue plus drain in the same cycle keeps q_count stable.
- Saturation up: from entry 0, apply 5 taken updates -> values 1, 2, 3, 3, 3; pred_taken=1 after the 2nd update.
- Assert rst with 3 updates queued mid-drain -> immediately q_count=0, pred_valid=0; after release, all entries read INIT; discarded updates have no effect.
